// File: rtl/rgbi_video_out.sv
// rgbi_video_out: RGBI-to-RGB video output stage for Williams-class cores.
// Generates the pixel clock enable and maps {channel, intensity} through a
// runtime-loadable brightness LUT that fills itself with c*i after reset.
// Blank/sync are delayed to stay aligned with colour.
// Optional light-gun crosshair overlay: define RGBI_VIDEO_OUT_CROSSHAIR_EN.
module rgbi_video_out #(
  parameter int CH_BITS  = 4,
  parameter int I_BITS   = 4,
  parameter int OUT_BITS = 8,
  parameter int CE_DIV   = 8,
  parameter int SWAP_RB  = 1
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [CH_BITS-1:0]          r_in,
  input  logic [CH_BITS-1:0]          g_in,
  input  logic [CH_BITS-1:0]          b_in,
  input  logic [I_BITS-1:0]           i_in,
  input  logic                        hblank_in,
  input  logic                        vblank_in,
  input  logic                        hs_in,
  input  logic                        vs_in,
  input  logic                        lut_wr,
  input  logic [CH_BITS+I_BITS-1:0]   lut_addr,
  input  logic [OUT_BITS-1:0]         lut_data,
  output logic                        ce_pix,
  output logic [OUT_BITS-1:0]         r_out,
  output logic [OUT_BITS-1:0]         g_out,
  output logic [OUT_BITS-1:0]         b_out,
  output logic                        hblank_out,
  output logic                        vblank_out,
  output logic                        hs_out,
  output logic                        vs_out,
  output logic                        init_done
`ifdef RGBI_VIDEO_OUT_CROSSHAIR_EN
  ,
  input  logic [8:0]                  gun_x,
  input  logic [7:0]                  gun_y,
  input  logic                        xhair_on
`endif
);

  localparam int AW    = CH_BITS + I_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(CE_DIV);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                init_addr_q, init_addr_d;
  logic                         init_done_q, init_done_d;
  logic [CW-1:0]                ce_cnt_q, ce_cnt_d;
  logic                         ce_pix_q, ce_pix_d;
  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [OUT_BITS-1:0]          wr_data;
  logic [AW-1:0]                init_prod;
  logic [OUT_BITS-1:0]          init_val;
  logic [CH_BITS-1:0]           r_sw, b_sw;
  logic [2:0][CH_BITS-1:0]      chan_s1_q, chan_s1_d;
  logic [I_BITS-1:0]            i_s1_q, i_s1_d;
  logic                         blk_s1_q, blk_s1_d, blk_s2_q, blk_s2_d;
  logic [3:0]                   tim_s1_q, tim_s1_d, tim_s2_q, tim_s2_d, tim_s3_q, tim_s3_d;
  logic [2:0][OUT_BITS-1:0]     rgb_q, rgb_d;
  logic [OUT_BITS-1:0]          lut_rd [3];

  // Default LUT contents: product of channel level and intensity, scaled to OUT_BITS
  assign init_prod = {{I_BITS{1'b0}}, init_addr_q[AW-1:I_BITS]} *
                     {{CH_BITS{1'b0}}, init_addr_q[I_BITS-1:0]};

  generate
    if (OUT_BITS >= AW) begin : g_val_shl
      assign init_val = OUT_BITS'(init_prod) << (OUT_BITS - AW);
    end else begin : g_val_msb
      assign init_val = init_prod[AW-1 -: OUT_BITS];
    end

    // The video chip wires R and B with a scrambled bit order
    if (SWAP_RB != 0) begin : g_swap
      assign r_sw = {r_in[1], r_in[2], r_in[3], r_in[0]};
      assign b_sw = {b_in[1], b_in[2], b_in[3], b_in[0]};
    end else begin : g_noswap
      assign r_sw = r_in;
      assign b_sw = b_in;
    end
  endgenerate

  // Three identical LUT copies so each channel has its own read port; old data on collision
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lut
      logic [OUT_BITS-1:0] mem [DEPTH];
      logic [OUT_BITS-1:0] rd_q;
      always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[{chan_s1_q[gi], i_s1_q}];
      end
      assign lut_rd[gi] = rd_q;
    end
  endgenerate

`ifdef RGBI_VIDEO_OUT_CROSSHAIR_EN
  logic [8:0] hcnt_q, hcnt_d, gx_q, gx_d;
  logic [7:0] vcnt_q, vcnt_d, gy_q, gy_d;
  logic       hb_prev_q, hb_prev_d, vb_prev_q, vb_prev_d;
  logic       xh_s1_q, xh_s1_d, xh_s2_q, xh_s2_d;
  logic [9:0] dx, adx;
  logic [8:0] dy, ady;

  // Beam position counters, gun position latched once per frame, crosshair hit test
  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    hb_prev_d = hblank_in;
    vb_prev_d = vblank_in;
    if (hblank_in)     hcnt_d = '0;
    else if (ce_pix_q) hcnt_d = hcnt_q + 9'd1;
    if (vblank_in)                     vcnt_d = '0;
    else if (hb_prev_q && !hblank_in)  vcnt_d = vcnt_q + 8'd1;
    if (vblank_in && !vb_prev_q) begin
      gx_d = gun_x;
      gy_d = gun_y;
    end
    dx  = {1'b0, hcnt_q} - {1'b0, gx_q};
    adx = dx[9] ? (10'd0 - dx) : dx;
    dy  = {1'b0, vcnt_q} - {1'b0, gy_q};
    ady = dy[8] ? (9'd0 - dy) : dy;
    xh_s1_d = xhair_on && !hblank_in && !vblank_in && init_done_q &&
              (((vcnt_q == gy_q) && (adx <= 10'd3)) ||
               ((hcnt_q == gx_q) && (ady <= 9'd3)));
    xh_s2_d = xh_s1_q;
  end

  // Crosshair state registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q <= '0; vcnt_q <= '0; gx_q <= '0; gy_q <= '0;
      hb_prev_q <= 1'b0; vb_prev_q <= 1'b0; xh_s1_q <= 1'b0; xh_s2_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d; vcnt_q <= vcnt_d; gx_q <= gx_d; gy_q <= gy_d;
      hb_prev_q <= hb_prev_d; vb_prev_q <= vb_prev_d; xh_s1_q <= xh_s1_d; xh_s2_q <= xh_s2_d;
    end
  end
`endif

  // Init sequencer: walk every LUT address once, then hand the write port to lut_wr
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    wr_en       = 1'b0;
    wr_addr     = lut_addr;
    wr_data     = lut_data;
    case (state_q)
      ST_INIT: begin
        wr_en       = 1'b1;
        wr_addr     = init_addr_q;
        wr_data     = init_val;
        init_addr_d = init_addr_q + AW'(1);
        if (&init_addr_q) state_d = ST_RUN;
      end
      default: wr_en = lut_wr;
    endcase
    init_done_d = (state_q == ST_RUN);
  end

  // Pixel enable divider and the three-stage colour/timing pipeline
  always_comb begin
    ce_cnt_d  = (ce_cnt_q == CW'(CE_DIV - 1)) ? '0 : ce_cnt_q + CW'(1);
    ce_pix_d  = (ce_cnt_q == '0);
    chan_s1_d = {b_sw, g_in, r_sw};
    i_s1_d    = i_in;
    blk_s1_d  = (i_in == '0) || hblank_in || vblank_in;
    tim_s1_d  = {hblank_in, vblank_in, hs_in, vs_in};
    blk_s2_d  = blk_s1_q;
    tim_s2_d  = tim_s1_q;
    tim_s3_d  = tim_s2_q;
    rgb_d     = '0;
    for (int c = 0; c < 3; c++) begin
      // Until the LUT is fully written its read data is not trustworthy
      if (init_done_q && !blk_s2_q) rgb_d[c] = lut_rd[c];
`ifdef RGBI_VIDEO_OUT_CROSSHAIR_EN
      if (xh_s2_q) rgb_d[c] = '1;
`endif
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      ce_cnt_q    <= '0;
      ce_pix_q    <= 1'b0;
      chan_s1_q   <= '0;
      i_s1_q      <= '0;
      blk_s1_q    <= 1'b0;
      blk_s2_q    <= 1'b0;
      tim_s1_q    <= '0;
      tim_s2_q    <= '0;
      tim_s3_q    <= '0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      ce_cnt_q    <= ce_cnt_d;
      ce_pix_q    <= ce_pix_d;
      chan_s1_q   <= chan_s1_d;
      i_s1_q      <= i_s1_d;
      blk_s1_q    <= blk_s1_d;
      blk_s2_q    <= blk_s2_d;
      tim_s1_q    <= tim_s1_d;
      tim_s2_q    <= tim_s2_d;
      tim_s3_q    <= tim_s3_d;
      rgb_q       <= rgb_d;
    end
  end

  assign ce_pix    = ce_pix_q;
  assign init_done = init_done_q;
  assign r_out     = rgb_q[0];
  assign g_out     = rgb_q[1];
  assign b_out     = rgb_q[2];
  assign {hblank_out, vblank_out, hs_out, vs_out} = tim_s3_q;

endmodule

// File: tb/tb_rgbi_video_out.sv
// Bench for rgbi_video_out (default build): scoreboard of expected pixels,
// checked by a separate monitor at the latency-3 output.
module tb_rgbi_video_out;
  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] r_in, g_in, b_in, i_in;
  logic       hblank_in, vblank_in, hs_in, vs_in, lut_wr;
  logic [7:0] lut_addr, lut_data;
  logic       ce_pix, init_done, hblank_out, vblank_out, hs_out, vs_out;
  logic [7:0] r_out, g_out, b_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    int          id;
    logic [27:0] exp;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [27:0] mon_act;

  rgbi_video_out dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .i_in(i_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in), .hs_in(hs_in), .vs_in(vs_in),
    .lut_wr(lut_wr), .lut_addr(lut_addr), .lut_data(lut_data),
    .ce_pix(ce_pix), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hblank_out(hblank_out), .vblank_out(vblank_out), .hs_out(hs_out), .vs_out(vs_out),
    .init_done(init_done)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Monitor: every output slot that has an expectation is compared
  always @(negedge clk_sys) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = {r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out};
      total++;
      if (mon_e.due != cyc) begin
        bad++;
        $display("FAIL txn%0d missed slot: due=%0d now=%0d", mon_e.id, mon_e.due, cyc);
      end else if (mon_act !== mon_e.exp) begin
        bad++;
        $display("FAIL txn%0d rgb/timing: got r=%h g=%h b=%h tim=%b, want r=%h g=%h b=%h tim=%b",
                 mon_e.id, mon_act[27:20], mon_act[19:12], mon_act[11:4], mon_act[3:0],
                 mon_e.exp[27:20], mon_e.exp[19:12], mon_e.exp[11:4], mon_e.exp[3:0]);
      end else begin
        $display("txn%0d ok r=%h g=%h b=%h tim=%b", mon_e.id,
                 mon_act[27:20], mon_act[19:12], mon_act[11:4], mon_act[3:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end else begin
      $display("%s ok value=%h", nm, act);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b00, ce_pix, init_done, r_out, g_out, b_out,
            hblank_out, vblank_out, hs_out, vs_out};
  endfunction

  task automatic set_idle();
    r_in = 0; g_in = 0; b_in = 0; i_in = 0;
    hblank_in = 0; vblank_in = 0; hs_in = 0; vs_in = 0;
    lut_wr = 0; lut_addr = 0; lut_data = 0;
  endtask

  // Drive one pixel (tim = {hblank, vblank, hs, vs}) and queue its expected output
  task automatic issue(input int id, input logic [3:0] r, input logic [3:0] g,
                       input logic [3:0] b, input logic [3:0] i, input logic [3:0] tim,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    exp_t e;
    r_in = r; g_in = g; b_in = b; i_in = i;
    {hblank_in, vblank_in, hs_in, vs_in} = tim;
    e.due = cyc + 3;
    e.id  = id;
    e.exp = {er, eg, eb, tim};
    sb.push_back(e);
  endtask

  initial begin
    logic [16:0] ce_pat;
    set_idle();
    reset_n = 1'b0;
    hs_in   = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("reset_outputs", all_outs(), 32'h0);
    hs_in   = 1'b0;
    reset_n = 1'b1;
    ce_pat  = '0;

    // INIT phase: n counts rising edges since release
    for (int n = 1; n <= 257; n++) begin
      @(negedge clk_sys);
      if (n <= 17) ce_pat[n-1] = ce_pix;
      if (n == 5) begin lut_wr = 1; lut_addr = 8'hFF; lut_data = 8'hAB; end
      if (n == 6) begin lut_wr = 0; issue(0, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0010, 8'd0, 8'd0, 8'd0); end
      if (n == 7) set_idle();
      if (n == 17) chk("ce_pix_pattern", {15'd0, ce_pat}, {15'd0, 17'h10101});
      if (n == 256) chk("init_done_at_256", {31'd0, init_done}, 32'd0);
      if (n == 257) chk("init_done_at_257", {31'd0, init_done}, 32'd1);
    end

    // RUN: swap, unswapped G, intensity-zero and blanking black rules
    issue(1, 4'b0010, 4'b0000, 4'b0000, 4'hF, 4'b0010, 8'd120, 8'd0, 8'd0);   @(negedge clk_sys);
    issue(2, 4'b0000, 4'b0010, 4'b0000, 4'hF, 4'b0001, 8'd0, 8'd30, 8'd0);    @(negedge clk_sys);
    issue(3, 4'b0000, 4'b0000, 4'b1000, 4'hF, 4'b0011, 8'd0, 8'd0, 8'd30);    @(negedge clk_sys);
    issue(4, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0000, 8'd225, 8'd225, 8'd225);        @(negedge clk_sys);
    issue(5, 4'hF, 4'hF, 4'hF, 4'h0, 4'b0010, 8'd0, 8'd0, 8'd0);              @(negedge clk_sys);
    issue(6, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1000, 8'd0, 8'd0, 8'd0);              @(negedge clk_sys);
    issue(7, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0100, 8'd0, 8'd0, 8'd0);              @(negedge clk_sys);
    issue(8, 4'd3, 4'd3, 4'd5, 4'd5, 4'b0001, 8'd45, 8'd15, 8'd25);           @(negedge clk_sys);
    issue(9, 4'hF, 4'd1, 4'd0, 4'd1, 4'b0011, 8'd15, 8'd1, 8'd0);             @(negedge clk_sys);

    // Write to {15,15} lands on the same edge that reads it for txn10
    issue(10, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0000, 8'd225, 8'd225, 8'd225);      @(negedge clk_sys);
    lut_wr = 1; lut_addr = 8'hFF; lut_data = 8'hAB;
    issue(11, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0010, 8'hAB, 8'hAB, 8'hAB);          @(negedge clk_sys);
    set_idle();
    repeat (4) @(negedge clk_sys);
    lut_wr = 1; lut_addr = 8'h35; lut_data = 8'h55;
    @(negedge clk_sys);
    lut_wr = 0;
    issue(12, 4'd0, 4'd3, 4'd0, 4'd5, 4'b0000, 8'd0, 8'h55, 8'd0);            @(negedge clk_sys);
    set_idle();
    repeat (5) @(negedge clk_sys);

    // Reset again, then interrupt INIT with a second reset at address 100
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (100) @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("reset_mid_init", all_outs(), 32'h0);
    reset_n = 1'b1;
    for (int n = 1; n <= 257; n++) begin
      @(negedge clk_sys);
      if (n == 256) chk("reinit_done_at_256", {31'd0, init_done}, 32'd0);
      if (n == 257) chk("reinit_done_at_257", {31'd0, init_done}, 32'd1);
    end
    issue(13, 4'd0, 4'd3, 4'd0, 4'd5, 4'b0000, 8'd0, 8'd15, 8'd0);            @(negedge clk_sys);
    issue(14, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0001, 8'd225, 8'd225, 8'd225);      @(negedge clk_sys);
    set_idle();
    repeat (5) @(negedge clk_sys);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
